tone_period_meter: RTL and testbench
====================================

# tone_period_meter

Measures the period and high time of an incoming square-wave tone, counted in system clock cycles. It is the receive-side counterpart of the clock divider that generates tones. A divided tone fed back through this block yields the divider's count, which closes the loop for self-test and tone calibration. It sits between the tone output pin or loopback and the control logic that checks pitch.

## Interface
- CNT_W, 22, width of the cycle counter and of the `period` and `high_time` outputs.
- MIN_PERIOD, 4, minimum accepted rise-to-rise spacing in clk cycles; closer rises are treated as glitches.
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  measurement enable; low forces IDLE.
- tone_in  input  1  asynchronous square wave under test.
- period  output  CNT_W  last measured rise-to-rise count in clk cycles.
- high_time  output  CNT_W  clk cycles from rise to fall within the same measured period.
- period_valid  output  1  one-cycle pulse when `period` and `high_time` update.
- no_signal  output  1  high until the first valid measurement, and after any timeout.

## Operation
- Input path:
  - `tone_in` passes through two synchronizer flops (`s1`, `s2`) and one history flop `s3`.
  - rise = `s2 & ~s3`; fall = `~s2 & s3`.
- Counter `cnt` (CNT_W bits):
  - Loads 1 on a recognized rise.
  - Otherwise increments each cycle while in MEASURE.
  - Saturates at all-ones; it never wraps.
- State machine:
  - IDLE: `cnt` is held.
    - rise with enable=1 → MEASURE, `cnt` <= 1, `hi_snap` <= 0.
  - MEASURE, fall: `hi_snap` <= `cnt` (first fall after the rise only).
  - MEASURE, rise with `cnt` >= MIN_PERIOD:
    - `period` <= `cnt`, `high_time` <= `hi_snap`, `period_valid` <= 1, `no_signal` <= 0.
    - `cnt` <= 1, `hi_snap` <= 0; stay in MEASURE.
  - MEASURE, rise with `cnt` < MIN_PERIOD: glitch.
    - Ignored; `cnt` keeps incrementing.
    - `hi_snap` is not re-armed, so a spurious fall after a glitch does not overwrite it.
  - MEASURE, `cnt` == all-ones and no rise: timeout.
    - `no_signal` <= 1, go to IDLE.
    - `period` and `high_time` keep their last values.
  - enable=0 in any state: next state IDLE, no `period_valid`.
    - `period`, `high_time` and `no_signal` are held.
- A rise and a timeout in the same cycle: the rise wins, and the measurement is taken with the saturated count.
- The first rise after IDLE only starts a measurement. No `period_valid` is produced for it.
- Reset values:
  - Outputs: `period`=0, `high_time`=0, `period_valid`=0, `no_signal`=1.
  - Internal: `s1`/`s2`/`s3`=0, `cnt`=0, `hi_snap`=0, state IDLE.
- Reset mid-measurement discards the partial count. The next rise starts afresh from IDLE.

## Timing
- Latency:
  - `tone_in` first sampled high at clk edge k: `s2` high after k+1, rise recognized in the cycle after k+1.
  - Register updates and `period_valid` are visible after clk edge k+2.
- Measured values:
  - An ideal tone of period P clk cycles (P >= MIN_PERIOD) yields `period` = P.
  - `high_time` = number of cycles `s2` was high in that period.
- `period_valid` is exactly one cycle wide. Consecutive pulses are at least MIN_PERIOD cycles apart.
- Timeout fires 2^CNT_W − 1 cycles after the last recognized rise.
- `enable` is synchronous and takes effect on the next clk edge.

## Test plan
- Steady divider-style tone:
  - Stimulus: high 1493 / low 1493 cycles, for 4 periods.
  - Response: first pulse after the second rise; `period`=2986, `high_time`=1493 on every pulse; `no_signal` falls with the first pulse.
- Asymmetric tone:
  - Stimulus: high 10 / low 30.
  - Response: `period`=40, `high_time`=10; `period_valid` exactly every 40 cycles.
- Glitch rejection:
  - Stimulus: period-100 tone with a 1-cycle pulse inserted 2 cycles after a rise.
  - Response: no extra `period_valid`; the following measurement reports `period`=100.
- Timeout, with CNT_W=8:
  - Stimulus: one period of 50, then `tone_in` held low.
  - Response: `period`=50 reported; `no_signal`=1 exactly 255 cycles after the last rise; `period` stays 50.
  - Recovery: a new tone of period 60 gives its first pulse only on the second rise, with `period`=60.
- Reset and enable:
  - Stimulus: assert `rst_n`=0 mid-period.
  - Response: all outputs return to their reset values immediately.
  - Stimulus: drop `enable` for 20 cycles during a period-40 tone.
  - Response: no pulses while `enable` is low, and values are held; after `enable` returns, the first pulse comes on the second rise and reports 40.

Source files
------------

// File: rtl/tone_period_meter.sv
// tone_period_meter: measures rise-to-rise period and high time of a square-wave tone in clk cycles.
module tone_period_meter #(
    parameter int CNT_W      = 22,
    parameter int MIN_PERIOD = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_tone_in,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_high_time,
    output logic             o_period_valid,
    output logic             o_no_signal
);
    typedef enum logic {IDLE, MEASURE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PERIOD);

    state_t           r_state, w_state_nx;
    logic             r_s1, r_s2, r_s3, r_armed;
    logic [CNT_W-1:0] r_cnt, r_hi_snap;
    logic             w_rise, w_fall, w_meas, w_start, w_take, w_timeout;

    assign w_rise = r_s2 & ~r_s3;
    assign w_fall = ~r_s2 & r_s3;

    always_comb begin
        w_meas     = r_state == MEASURE && i_enable;
        w_start    = r_state == IDLE && i_enable && w_rise;
        w_take     = w_meas && w_rise && r_cnt >= MIN_CNT;
        w_timeout  = w_meas && !w_rise && r_cnt == CNT_MAX;
        w_state_nx = !i_enable ? IDLE : w_start ? MEASURE : w_timeout ? IDLE : r_state;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1           <= 1'b0;
            r_s2           <= 1'b0;
            r_s3           <= 1'b0;
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_hi_snap      <= '0;
            r_armed        <= 1'b0;
            o_period       <= '0;
            o_high_time    <= '0;
            o_period_valid <= 1'b0;
            o_no_signal    <= 1'b1;
        end else begin
            r_s1           <= i_tone_in;
            r_s2           <= r_s1;
            r_s3           <= r_s2;
            r_state        <= w_state_nx;
            o_period_valid <= w_take;
            if (w_start || w_take) begin
                r_cnt     <= CNT_W'(1);
                r_hi_snap <= '0;
                r_armed   <= 1'b1;
            end else if (w_meas) begin
                if (r_cnt != CNT_MAX)
                    r_cnt <= r_cnt + 1'b1;
                // only the first fall after an accepted rise counts, so glitch falls are ignored
                if (w_fall && r_armed) begin
                    r_hi_snap <= r_cnt;
                    r_armed   <= 1'b0;
                end
            end
            if (w_take) begin
                o_period    <= r_cnt;
                o_high_time <= r_hi_snap;
                o_no_signal <= 1'b0;
            end
            if (w_timeout)
                o_no_signal <= 1'b1;
        end
    end
endmodule

// File: tb/tb_tone_period_meter.sv
// tb_tone_period_meter: random and directed tones against a timestamp-based reference model,
// run on a default-width instance and an 8-bit instance in parallel.
module tb_tone_period_meter;
    localparam int MINP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        tone = 1'b0;
    logic [21:0] per0, hi0;
    logic [7:0]  per1, hi1;
    logic        v0, v1, ns0, ns1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tone_period_meter #(.CNT_W(22), .MIN_PERIOD(MINP)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_tone_in(tone),
        .o_period(per0), .o_high_time(hi0), .o_period_valid(v0), .o_no_signal(ns0)
    );

    tone_period_meter #(.CNT_W(8), .MIN_PERIOD(MINP)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_tone_in(tone),
        .o_period(per1), .o_high_time(hi1), .o_period_valid(v1), .o_no_signal(ns1)
    );

    // Reference model: times events with an absolute cycle stamp rather than a counter.
    logic [63:0] q0[$], q1[$];
    int  maxv[2] = '{4194303, 255};
    int  t = 0;
    int  t0[2], hs[2], ep[2], eh[2];
    bit  act[2], armed[2], ens[2] = '{1'b1, 1'b1};
    bit  m1, m2, m3;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1 = 0; m2 = 0; m3 = 0;
            q0.delete(); q1.delete();
            for (int i = 0; i < 2; i++) begin
                act[i] = 0; armed[i] = 0; hs[i] = 0; ep[i] = 0; eh[i] = 0; ens[i] = 1;
            end
        end else begin
            bit rise, fall;
            int c;
            t++;
            rise = m2 & ~m3;
            fall = ~m2 & m3;
            for (int i = 0; i < 2; i++) begin
                if (!enable) act[i] = 0;
                else if (!act[i]) begin
                    if (rise) begin act[i] = 1; t0[i] = t; hs[i] = 0; armed[i] = 1; end
                end else begin
                    c = (t - t0[i] > maxv[i]) ? maxv[i] : t - t0[i];
                    if (rise && c >= MINP) begin
                        if (i == 0) q0.push_back({32'(c), 32'(hs[i])});
                        else        q1.push_back({32'(c), 32'(hs[i])});
                        ep[i] = c; eh[i] = hs[i]; ens[i] = 0;
                        t0[i] = t; hs[i] = 0; armed[i] = 1;
                    end else if (fall && armed[i]) begin
                        hs[i] = c; armed[i] = 0;
                    end
                    if (!rise && c == maxv[i]) begin act[i] = 0; ens[i] = 1; end
                end
            end
            m3 = m2; m2 = m1; m1 = tone;
        end
    end

    task automatic check(input int i, input bit v, input int p, input int h, input bit n);
        logic [63:0] e;
        bit have;
        have = 0;
        e = '0;
        if (i == 0) begin if (q0.size() > 0) begin have = 1; e = q0.pop_front(); end end
        else        begin if (q1.size() > 0) begin have = 1; e = q1.pop_front(); end end
        if (v || have) begin
            n_cmp++;
            if (!v || !have || p != int'(e[63:32]) || h != int'(e[31:0])) begin
                n_bad++;
                $display("FAIL pulse dut%0d t=%0d: valid=%0b period=%0d high=%0d, expected pulse=%0b period=%0d high=%0d",
                         i, t, v, p, h, have, e[63:32], e[31:0]);
            end
        end
        n_cmp++;
        if (p != ep[i] || h != eh[i] || n != ens[i]) begin
            n_bad++;
            $display("FAIL hold dut%0d t=%0d: period=%0d high=%0d no_signal=%0b, expected %0d %0d %0b",
                     i, t, p, h, n, ep[i], eh[i], ens[i]);
        end
    endtask

    always @(negedge clk) begin
        check(0, v0, int'(per0), int'(hi0), ns0);
        check(1, v1, int'(per1), int'(hi1), ns1);
    end

    task automatic chk(input string name, input int act_v, input int exp_v);
        n_cmp++;
        if (act_v != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act_v, exp_v);
        end
    endtask

    task automatic seg(input int h, input int l);
        tone = 1'b1;
        repeat (h) @(negedge clk);
        tone = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_period", int'(per0), 0);
        chk("reset_high", int'(hi0), 0);
        chk("reset_valid", int'(v0), 0);
        chk("reset_nosig", int'(ns0), 1);
        rst_n = 1'b1;
        enable = 1'b1;
        repeat (4) @(negedge clk);

        repeat (5) seg(1493, 1493);
        chk("steady_period", int'(per0), 2986);
        chk("steady_high", int'(hi0), 1493);
        chk("steady_nosig", int'(ns0), 0);

        repeat (6) seg(10, 30);
        chk("asym_period", int'(per0), 40);
        chk("asym_high", int'(hi0), 10);

        repeat (4) begin seg(1, 1); seg(1, 97); end
        seg(1, 5);
        chk("glitch_period", int'(per0), 100);
        chk("glitch_period8", int'(per1), 100);
        chk("glitch_high", int'(hi0), 1);

        seg(25, 25);
        seg(25, 300);
        chk("timeout_nosig8", int'(ns1), 1);
        chk("timeout_period8", int'(per1), 50);
        chk("timeout_high8", int'(hi1), 25);
        repeat (3) seg(30, 30);
        chk("recover_period8", int'(per1), 60);
        chk("recover_nosig8", int'(ns1), 0);

        seg(20, 10);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_period", int'(per0), 0);
        chk("midrst_high", int'(hi0), 0);
        chk("midrst_valid", int'(v0), 0);
        chk("midrst_nosig", int'(ns0), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seg(0, 10);

        fork
            repeat (8) seg(20, 20);
            begin
                repeat (95) @(negedge clk);
                enable = 1'b0;
                repeat (20) @(negedge clk);
                enable = 1'b1;
            end
        join
        chk("enable_period", int'(per0), 40);

        repeat (60) begin
            if ($urandom_range(0, 9) == 0) enable = ~enable;
            seg($urandom_range(1, 40), $urandom_range(1, 40));
        end
        enable = 1'b1;
        repeat (10) seg($urandom_range(1, 60), $urandom_range(1, 60));
        repeat (10) @(negedge clk);
        chk("queue0_drained", q0.size(), 0);
        chk("queue1_drained", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
